// File: rtl/uart_tx_fifo.sv
// Byte FIFO and issue sequencer feeding the UART transmitter, paced on its busy flag.
// Optional fill-level outputs (level_o, afull_o) are enabled by defining UART_TX_FIFO_LEVEL_EN.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          clk_50m_i,
    input  logic          rst_i,
    input  logic [7:0]    wr_data_i,
    input  logic          wr_en_i,
    output logic          full_o,
    output logic          empty_o,
    output logic          overflow_o,
    input  logic          clr_ovf_i,
    output logic [7:0]    tx_din_o,
    output logic          tx_wren_o,
    input  logic          tx_busy_i
`ifdef UART_TX_FIFO_LEVEL_EN
    ,
    output logic [AW:0]   level_o,
    output logic          afull_o
`endif
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_WAIT_HI = 2'd2;
    localparam logic [1:0] S_WAIT_LO = 2'd3;

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    din_q, din_d;
    logic          wren_q, wren_d;
    logic [1:0]    state_q, state_d;

    logic          push;
    logic          pop;
    logic          drop;

    // Flags come from the registered count, so a pop never frees a slot
    // for a write arriving in the same cycle.
    always_comb begin
        push = wr_en_i && !full_q;
        drop = wr_en_i && full_q;
        pop  = (state_q == S_IDLE) && !empty_q && !tx_busy_i;
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        full_d  = (count_d == FULL_CNT);
        empty_d = (count_d == '0);
    end

    // A drop in the same cycle as a clear keeps the flag set.
    always_comb begin
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf_i) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_comb begin
        state_d = state_q;
        wren_d  = 1'b0;
        din_d   = din_q;

        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    din_d   = mem_q[rd_ptr_q];
                    wren_d  = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                // Transmitter raises busy one cycle after it samples wren.
                if (tx_busy_i) begin
                    state_d = S_WAIT_LO;
                end
            end
            S_WAIT_LO: begin
                if (!tx_busy_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_50m_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_50m_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
            din_q    <= '0;
            wren_q   <= 1'b0;
            state_q  <= S_IDLE;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
            din_q    <= din_d;
            wren_q   <= wren_d;
            state_q  <= state_d;
        end
    end

    assign full_o     = full_q;
    assign empty_o    = empty_q;
    assign overflow_o = ovf_q;
    assign tx_din_o   = din_q;
    assign tx_wren_o  = wren_q;

`ifdef UART_TX_FIFO_LEVEL_EN
    logic afull_q;

    always_ff @(posedge clk_50m_i) begin
        if (rst_i) begin
            afull_q <= 1'b0;
        end else begin
            afull_q <= (count_d >= (AW+1)'(DEPTH - 2));
        end
    end

    assign level_o = count_q;
    assign afull_o = afull_q;
`endif

    a_wren_single: assert property (@(posedge clk_50m_i) disable iff (rst_i)
        wren_q |=> !wren_q);

    a_flags_excl: assert property (@(posedge clk_50m_i) disable iff (rst_i)
        !(full_q && empty_q));

    a_count_range: assert property (@(posedge clk_50m_i) disable iff (rst_i)
        count_q <= FULL_CNT);

    a_ptr_count: assert property (@(posedge clk_50m_i) disable iff (rst_i)
        (wr_ptr_q - rd_ptr_q) == count_q[AW-1:0]);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo with a simple transmitter busy model.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       clr_ovf;
    logic [7:0] tx_din;
    logic       tx_wren;
    logic       tx_busy;
`ifdef UART_TX_FIFO_LEVEL_EN
    logic [4:0] level;
    logic       afull;
`endif

    logic       busy_force;
    logic       mdl_en;
    int         busy_len;
    int         busy_cnt;
    int         cyc;

    int         n_cmp;
    int         n_fail;
    int         n_dbl;
    int         n_bviol;
    logic       prev_wren;

    logic [7:0] log_d[$];
    int         log_t[$];

    always #5 clk = ~clk;

    uart_tx_fifo #(.DEPTH(16), .AW(4)) dut (
        .clk_50m_i  (clk),
        .rst_i      (rst),
        .wr_data_i  (wr_data),
        .wr_en_i    (wr_en),
        .full_o     (full),
        .empty_o    (empty),
        .overflow_o (ovf),
        .clr_ovf_i  (clr_ovf),
        .tx_din_o   (tx_din),
        .tx_wren_o  (tx_wren),
        .tx_busy_i  (tx_busy)
`ifdef UART_TX_FIFO_LEVEL_EN
        ,
        .level_o    (level),
        .afull_o    (afull)
`endif
    );

    // Transmitter model: busy rises the cycle after it samples wren and lasts busy_len cycles.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tx_wren === 1'b1) busy_cnt <= busy_len;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end

    assign tx_busy = mdl_en ? (busy_cnt != 0) : busy_force;

    always @(negedge clk) begin
        if (tx_wren === 1'b1) begin
            log_d.push_back(tx_din);
            log_t.push_back(cyc);
            if (prev_wren) n_dbl <= n_dbl + 1;
            if (tx_busy === 1'b1) n_bviol <= n_bviol + 1;
        end
        prev_wren <= (tx_wren === 1'b1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_log(input int n, input int limit);
        for (int i = 0; i < limit && log_d.size() < n; i++) tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0; n_fail = 0; n_dbl = 0; n_bviol = 0; prev_wren = 1'b0;
        rst = 1'b1; wr_data = '0; wr_en = 1'b0; clr_ovf = 1'b0;
        busy_force = 1'b0; mdl_en = 1'b0; busy_len = 10;

        // Reset state
        do_reset();
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_ovf", ovf, 0);
        check("rst_wren", tx_wren, 0);
        check("rst_din", tx_din, 8'h00);

        // Single byte latency
        wr_data = 8'hA5; wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        check("t1_not_empty", empty, 0);
        check("t1_wren_early", tx_wren, 0);
        tick();
        check("t1_wren", tx_wren, 1);
        check("t1_din", tx_din, 8'hA5);
        tick();
        check("t1_wren_off", tx_wren, 0);
        check("t1_empty_after", empty, 1);
        check("t1_din_hold", tx_din, 8'hA5);

        // Three bytes paced by the busy model
        mdl_en = 1'b1;
        do_reset();
        log_d.delete(); log_t.delete();
        wr_en = 1'b1;
        wr_data = 8'h11; tick();
        wr_data = 8'h22; tick();
        wr_data = 8'h33; tick();
        wr_en = 1'b0;
        wait_log(3, 100);
        check("t2_count", log_d.size(), 3);
        check("t2_b0", log_d[0], 8'h11);
        check("t2_b1", log_d[1], 8'h22);
        check("t2_b2", log_d[2], 8'h33);
        check("t2_gap01", log_t[1] - log_t[0], 13);
        check("t2_gap12", log_t[2] - log_t[1], 13);
        for (int i = 0; i < 20; i++) tick();

        // Fill with busy held high, overflow and clear
        mdl_en = 1'b0; busy_force = 1'b1;
        do_reset();
        for (int i = 0; i < 15; i++) begin
            wr_data = 8'(i); wr_en = 1'b1;
            tick();
        end
        check("t3_full_15", full, 0);
        wr_data = 8'd15;
        tick();
        check("t3_full_16", full, 1);
        check("t3_ovf_16", ovf, 0);
        wr_data = 8'hEE;
        tick();
        wr_en = 1'b0;
        check("t3_ovf_17", ovf, 1);
        check("t3_full_17", full, 1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("t3_ovf_clr", ovf, 0);
        wr_data = 8'hEF; wr_en = 1'b1; clr_ovf = 1'b1;
        tick();
        wr_en = 1'b0; clr_ovf = 1'b0;
        check("t3_drop_wins", ovf, 1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("t3_ovf_clr2", ovf, 0);

        // Release busy and write in the pop cycle
        log_d.delete(); log_t.delete();
        busy_force = 1'b0;
        wr_data = 8'hF0; wr_en = 1'b1;
        tick();
        check("t4_pop_wren", tx_wren, 1);
        check("t4_pop_din", tx_din, 8'h00);
        check("t4_full_after_pop", full, 0);
        check("t4_drop_ovf", ovf, 1);
        mdl_en = 1'b1;
        wr_data = 8'hF1;
        tick();
        wr_en = 1'b0;
        check("t4_next_accept", full, 1);
        wait_log(17, 400);
        check("t4_count", log_d.size(), 17);
        for (int i = 0; i < 17; i++) begin
            check("t4_byte", log_d[i], (i < 16) ? i : 8'hF1);
        end
        for (int i = 0; i < 30; i++) tick();
        check("t4_no_extra", log_d.size(), 17);
        check("t4_empty", empty, 1);

        // Wrap: 40 bytes with continuous drain
        busy_len = 2;
        do_reset();
        log_d.delete(); log_t.delete();
        for (int i = 0; i < 40; i++) begin
            for (int w = 0; w < 50 && full; w++) tick();
            wr_data = 8'(i); wr_en = 1'b1;
            tick();
            wr_en = 1'b0;
        end
        wait_log(40, 600);
        check("t5_count", log_d.size(), 40);
        for (int i = 0; i < 40; i++) begin
            check("t5_byte", log_d[i], i);
        end
        for (int i = 0; i < 20; i++) tick();
        check("t5_no_extra", log_d.size(), 40);
        check("t5_ovf", ovf, 0);

        // Reset while waiting for busy to fall, with bytes still queued
        busy_len = 10;
        do_reset();
        log_d.delete(); log_t.delete();
        wr_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wr_data = 8'h51 + 8'(i);
            tick();
        end
        wr_en = 1'b0;
        for (int i = 0; i < 20 && !tx_busy; i++) tick();
        check("t6_busy_seen", tx_busy, 1);
        tick(); tick();
        check("t6_queued", empty, 0);
        do_reset();
        log_d.delete(); log_t.delete();
        check("t6_empty", empty, 1);
        check("t6_wren", tx_wren, 0);
        check("t6_ovf", ovf, 0);
        check("t6_full", full, 0);
        for (int i = 0; i < 30; i++) tick();
        check("t6_no_strobe", log_d.size(), 0);
        wr_data = 8'h77; wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        wait_log(1, 40);
        check("t6_new_count", log_d.size(), 1);
        check("t6_new_byte", log_d[0], 8'h77);

        check("wren_double", n_dbl, 0);
        check("wren_while_busy", n_bviol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
